mole_round_ctrl: RTL and testbench

//   Round sequencer for the whack-a-mole game. Places the mole at a pseudo-random

---
 rtl/mole_pkg.sv | 21 ++
 rtl/mole_lfsr.sv | 15 +
 rtl/mole_round_ctrl.sv | 135 +++++++++++++
 tb/tb_mole_round_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package mole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int         POS_W_DEF = 2;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Galois form of x^8+x^6+x^5+x^4+1, shifting right
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Galois LFSR; nonzero seed keeps it out of the lock-up state.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rnd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rnd <= LFSR_SEED;
    else        rnd <= lfsr_next(rnd);
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: places the mole, times the window, judges
// presses and keeps score/miss counts until the game ends.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   SPAWN | pick a new hole, load hold timer
//   SHOW  | mole up, judging presses / timeout
//   GAP   | mole down between rounds
//   OVER  | game ended, counts frozen until start
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int POS_W       = POS_W_DEF,
  parameter int SCORE_W     = 8,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_MISSES  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               space,
  input  logic [POS_W-1:0]   num,
  output logic [POS_W-1:0]   pos,
  output logic               mole_active,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         misses,
  output logic               game_over
);

  localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       MISS_END = 3'(MAX_MISSES);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic             space_q;
  logic [7:0]       rnd;
  logic             unused_rnd;

  logic             press;
  logic             in_show;
  logic             timeout;
  logic             good_hit;
  logic             bad_round;
  logic             judged;
  logic [2:0]       misses_inc;
  logic             end_game;
  logic             start_game;
  logic [POS_W-1:0] rnd_pos;
  logic [POS_W-1:0] spawn_pos;

  mole_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .rnd   (rnd)
  );

  // Only the low bits pick the hole; the rest just keep the sequence long.
  assign unused_rnd = ^rnd;

  assign press      = space & ~space_q;
  assign in_show    = (state == ST_SHOW);
  assign timeout    = (timer == '0);
  assign good_hit   = press && (num == pos);
  assign judged     = press || timeout;
  assign bad_round  = judged && !good_hit;
  assign misses_inc = misses + 3'd1;
  assign end_game   = (misses_inc == MISS_END);
  assign start_game = start && ((state == ST_IDLE) || (state == ST_OVER));
  assign rnd_pos    = rnd[POS_W-1:0];
  // Never repeat the previous hole: bump to the neighbour instead.
  assign spawn_pos  = (rnd_pos == pos) ? pos + POS_W'(1) : rnd_pos;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SPAWN;
      ST_SPAWN: state_nxt = ST_SHOW;
      ST_SHOW:  if (judged) state_nxt = (bad_round && end_game) ? ST_OVER : ST_GAP;
      ST_GAP:   if (timeout) state_nxt = ST_SPAWN;
      ST_OVER:  if (start) state_nxt = ST_SPAWN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      space_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      space_q <= space;
      case (state)
        ST_SPAWN: timer <= HOLD_LD;
        ST_SHOW:  timer <= judged ? GAP_LD : timer - TMR_W'(1);
        ST_GAP:   if (!timeout) timer <= timer - TMR_W'(1);
        default:  timer <= timer;
      endcase
    end
  end

  // Outputs follow state_nxt so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos         <= '0;
      mole_active <= 1'b0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      score       <= '0;
      misses      <= '0;
      game_over   <= 1'b0;
    end else begin
      hit         <= in_show && good_hit;
      miss        <= in_show && bad_round;
      mole_active <= (state_nxt == ST_SHOW);
      game_over   <= (state_nxt == ST_OVER);
      if (state == ST_SPAWN) pos <= spawn_pos;
      if (start_game) begin
        score  <= '0;
        misses <= '0;
      end else if (in_show) begin
        if (good_hit && (score != '1)) score <= score + SCORE_W'(1);
        if (bad_round)                 misses <= misses_inc;
      end
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: table of rounds plus hand-written corner sequences.
module tb_mole_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       space;
  logic [1:0] num;
  logic [1:0] pos;
  logic       mole_active;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic [2:0] misses;
  logic       game_over;

  int n_pass  = 0;
  int n_total = 0;

  mole_round_ctrl #(
    .POS_W(2), .SCORE_W(8), .HOLD_CYCLES(8), .GAP_CYCLES(4), .MAX_MISSES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .space(space), .num(num),
    .pos(pos), .mole_active(mole_active), .hit(hit), .miss(miss),
    .score(score), .misses(misses), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1 Galois, seed A5
  logic [7:0] m_lfsr, m_prev;
  function automatic logic [7:0] m_next(input logic [7:0] v);
    logic [7:0] r;
    r = {1'b0, v[7:1]};
    if (v[0]) r = r ^ 8'b1011_1000;
    return r;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= m_next(m_lfsr);
    end
  end

  logic [1:0] exp_pos;

  typedef struct {
    int act;     // 0 correct press, 1 wrong press, 2 no press
    int dly;     // SHOW cycles before the press
    int e_hit;
    int e_miss;
    int e_score;
    int e_misses;
    int e_over;
    int gap;     // check GAP+SPAWN length afterwards
    int keep;    // keep space held after the press
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic wait_show();
    int k;
    logic [1:0] v;
    logic [1:0] e;
    k = 0;
    while (!mole_active && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("show_reached", int'(mole_active), 1);
    v = m_prev[1:0];
    e = (v == exp_pos) ? v + 2'd1 : v;
    chk("spawn_pos", int'(pos), int'(e));
    chk("pos_changed", int'(pos != exp_pos), 1);
    exp_pos = e;
  endtask

  task automatic play_round(input vec_t t);
    int up;
    int low;
    wait_show();
    if (t.act == 2) begin
      up = 1;
      while (mole_active && up < 30) begin
        @(negedge clk);
        if (mole_active) up++;
      end
      chk("show_len", up, 8);
    end else begin
      repeat (t.dly) @(negedge clk);
      num   = (t.act == 0) ? exp_pos : exp_pos + 2'd1;
      space = 1'b1;
      @(negedge clk);
      chk("active_drop", int'(mole_active), 0);
    end
    chk("hit", int'(hit), t.e_hit);
    chk("miss", int'(miss), t.e_miss);
    chk("score", int'(score), t.e_score);
    chk("misses", int'(misses), t.e_misses);
    chk("game_over", int'(game_over), t.e_over);
    if (t.keep == 0) space = 1'b0;
    @(negedge clk);
    chk("pulse_1cyc", int'(hit | miss), 0);
    if (t.gap != 0) begin
      low = 2;
      while (!mole_active && low < 30) begin
        @(negedge clk);
        if (!mole_active) low++;
      end
      chk("gap_len", low, 5);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t tbl[7];
  vec_t v;
  int   seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0, 1, 0, 1, 0, 0, 1, 0};
    tbl[1] = '{0, 3, 1, 0, 2, 0, 0, 1, 0};
    tbl[2] = '{1, 2, 0, 1, 2, 1, 0, 1, 0};
    tbl[3] = '{0, 7, 1, 0, 3, 1, 0, 1, 0};  // press on the timeout cycle
    tbl[4] = '{2, 0, 0, 1, 3, 2, 0, 1, 0};  // timeout
    tbl[5] = '{0, 5, 1, 0, 4, 2, 0, 1, 0};
    tbl[6] = '{1, 0, 0, 1, 4, 3, 1, 0, 0};  // third miss ends the game

    rst_n = 1'b0; start = 1'b0; space = 1'b0; num = 2'd0;
    exp_pos = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_pos", int'(pos), 0);
    chk("rst_active", int'(mole_active), 0);
    chk("rst_pulses", int'(hit | miss), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_misses", int'(misses), 0);
    chk("rst_over", int'(game_over), 0);
    rst_n = 1'b1;
    @(negedge clk);

    pulse_start();
    for (int i = 0; i < 7; i++) play_round(tbl[i]);

    // Presses during OVER do nothing
    space = 1'b1;
    repeat (2) @(negedge clk);
    chk("over_pulses", int'(hit | miss), 0);
    chk("over_score", int'(score), 4);
    chk("over_misses", int'(misses), 3);
    chk("over_active", int'(mole_active), 0);
    space = 1'b0;
    @(negedge clk);

    pulse_start();
    chk("restart_score", int'(score), 0);
    chk("restart_misses", int'(misses), 0);
    chk("restart_over", int'(game_over), 0);

    // 20 rounds of correct presses; start held during one to show it is ignored
    for (int i = 0; i < 20; i++) begin
      v = '{0, i % 8, 1, 0, i + 1, 0, 0, 1, 0};
      if (i == 10) start = 1'b1;
      play_round(v);
      start = 1'b0;
    end

    // Hit then keep space down into the next round: that round times out
    v = '{0, 1, 1, 0, 21, 0, 0, 1, 1};
    play_round(v);
    v = '{2, 0, 0, 1, 21, 1, 0, 1, 1};
    play_round(v);
    space = 1'b0;

    // Asynchronous reset mid-SHOW
    wait_show();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pos", int'(pos), 0);
    chk("arst_active", int'(mole_active), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_misses", int'(misses), 0);
    chk("arst_over", int'(game_over), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pos = 2'd0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (mole_active) seen = 1;
    end
    chk("idle_after_rst", seen, 0);

    // Score saturation at 255
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      v = '{0, 0, 1, 0, (i + 1 > 255) ? 255 : i + 1, 0, 0, 1, 0};
      play_round(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
